// File: rtl/mtcmos_pkg.sv
// Shared types and default sizing for the MTCMOS sleep sequencer.
package mtcmos_pkg;

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'b00,
    ST_ENTER  = 2'b01,
    ST_SLEEP  = 2'b10,
    ST_WAKE   = 2'b11
  } state_t;

  localparam int DEF_IDLE_CYCLES = 16;
  localparam int DEF_WAKE_CYCLES = 4;
  localparam int DEF_CNT_W       = 8;

endpackage

// File: rtl/mtcmos_sat_cnt.sv
// Up-counter with synchronous clear and enable that holds once it reaches i_limit.
module mtcmos_sat_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_limit,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != i_limit)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/mtcmos_sleep_ctrl.sv
// Power-gating sequencer producing the sleep pin of the MTCMOS flop bank.
// Optional sleep-entry statistics counter enabled by MTCMOS_SLEEP_STATS_EN.
module mtcmos_sleep_ctrl
  import mtcmos_pkg::*;
#(
  parameter int IDLE_CYCLES = DEF_IDLE_CYCLES,
  parameter int WAKE_CYCLES = DEF_WAKE_CYCLES,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        activity,
  input  logic        sleep_req,
  input  logic        wake_req,
  output logic        sleep,
  output logic        ready,
  output logic [1:0]  state_o,
  output logic [15:0] sleep_count
);

  localparam logic [CNT_W-1:0] IDLE_LIM = CNT_W'(IDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAKE_LIM = CNT_W'(WAKE_CYCLES - 1);

  state_t           r_state;
  logic             r_sleep;
  logic             r_ready;
  logic [CNT_W-1:0] w_idle_cnt;
  logic [CNT_W-1:0] w_wake_cnt;
  logic             w_idle_clr;
  logic             w_idle_en;
  logic             w_wake_clr;
  logic             w_wake_en;

  // Counters are held at zero outside their own state, so each state is entered with a fresh count.
  assign w_idle_clr = (r_state != ST_ACTIVE) || activity;
  assign w_idle_en  = (r_state == ST_ACTIVE);
  assign w_wake_clr = (r_state != ST_WAKE);
  assign w_wake_en  = (r_state == ST_WAKE);

  mtcmos_sat_cnt #(.CNT_W(CNT_W)) u_idle_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_idle_clr),
    .i_en    (w_idle_en),
    .i_limit (IDLE_LIM),
    .o_cnt   (w_idle_cnt)
  );

  mtcmos_sat_cnt #(.CNT_W(CNT_W)) u_wake_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_wake_clr),
    .i_en    (w_wake_en),
    .i_limit (WAKE_LIM),
    .o_cnt   (w_wake_cnt)
  );

  // Outputs are registered alongside the state so they decode the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_ACTIVE;
      r_sleep <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      unique case (r_state)
        ST_ACTIVE: begin
          if (!activity && ((w_idle_cnt == IDLE_LIM) || sleep_req)) begin
            r_state <= ST_ENTER;
            r_sleep <= 1'b0;
            r_ready <= 1'b0;
          end
        end
        ST_ENTER: begin
          r_state <= ST_SLEEP;
          r_sleep <= 1'b1;
          r_ready <= 1'b0;
        end
        ST_SLEEP: begin
          if (wake_req || activity) begin
            r_state <= ST_WAKE;
            r_sleep <= 1'b0;
            r_ready <= 1'b0;
          end
        end
        ST_WAKE: begin
          if (w_wake_cnt == WAKE_LIM) begin
            r_state <= ST_ACTIVE;
            r_sleep <= 1'b0;
            r_ready <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_ACTIVE;
          r_sleep <= 1'b0;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign sleep   = r_sleep;
  assign ready   = r_ready;
  assign state_o = r_state;

`ifdef MTCMOS_SLEEP_STATS_EN
  logic [15:0] r_sleep_count;

  // ENTER always advances to SLEEP, so each ENTER cycle is one completed entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sleep_count <= '0;
    end else if ((r_state == ST_ENTER) && (r_sleep_count != '1)) begin
      r_sleep_count <= r_sleep_count + 16'd1;
    end
  end

  assign sleep_count = r_sleep_count;
`else
  assign sleep_count = '0;
`endif

endmodule

// File: tb/tb_mtcmos_sleep_ctrl.sv
// Self-checking bench for mtcmos_sleep_ctrl: directed scenarios plus randomized traffic vs. a behavioural model.
module tb_mtcmos_sleep_ctrl;

  localparam int IDLE = 4;
  localparam int WAKE = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        activity;
  logic        sleep_req;
  logic        wake_req;
  logic        sleep;
  logic        ready;
  logic [1:0]  state_o;
  logic [15:0] sleep_count;

  int n_total = 0;
  int n_pass  = 0;

  mtcmos_sleep_ctrl #(
    .IDLE_CYCLES (IDLE),
    .WAKE_CYCLES (WAKE),
    .CNT_W       (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .activity    (activity),
    .sleep_req   (sleep_req),
    .wake_req    (wake_req),
    .sleep       (sleep),
    .ready       (ready),
    .state_o     (state_o),
    .sleep_count (sleep_count)
  );

  always #5 clk = ~clk;

  // Behavioural model: power status flags and remaining-time counters rather than a state register.
  int m_idle_run;
  bit m_guard;
  bit m_gated;
  int m_settle_left;
  int m_entries;

  function automatic void model_reset();
    m_idle_run    = 0;
    m_guard       = 1'b0;
    m_gated       = 1'b0;
    m_settle_left = 0;
    m_entries     = 0;
  endfunction

  function automatic void model_edge(input bit a, input bit s, input bit w);
    if (m_guard) begin
      m_guard = 1'b0;
      m_gated = 1'b1;
      if (m_entries < 65535) m_entries++;
    end else if (m_gated) begin
      if (w || a) begin
        m_gated       = 1'b0;
        m_settle_left = WAKE;
      end
    end else if (m_settle_left > 0) begin
      m_settle_left--;
      if (m_settle_left == 0) m_idle_run = 0;
    end else if (a) begin
      m_idle_run = 0;
    end else begin
      m_idle_run++;
      if (m_idle_run >= IDLE || s) m_guard = 1'b1;
    end
  endfunction

  function automatic logic [15:0] exp_state();
    if (m_guard)              return 16'd1;
    else if (m_gated)         return 16'd2;
    else if (m_settle_left>0) return 16'd3;
    else                      return 16'd0;
  endfunction

  function automatic logic [15:0] exp_ready();
    return (!m_guard && !m_gated && m_settle_left == 0) ? 16'd1 : 16'd0;
  endfunction

  function automatic logic [15:0] exp_count();
`ifdef MTCMOS_SLEEP_STATS_EN
    return 16'(m_entries);
`else
    return 16'd0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".state"}, {14'd0, state_o}, exp_state());
    chk({tag, ".sleep"}, {15'd0, sleep}, {15'd0, m_gated});
    chk({tag, ".ready"}, {15'd0, ready}, exp_ready());
    chk({tag, ".count"}, sleep_count, exp_count());
  endtask

  // Inputs change just after a falling edge; outputs are checked on the next falling edge.
  task automatic cyc(input bit a, input bit s, input bit w, input string tag);
    activity  = a;
    sleep_req = s;
    wake_req  = w;
    @(posedge clk);
    model_edge(a, s, w);
    @(negedge clk);
    chk_all(tag);
  endtask

  task automatic do_reset(input string tag);
    activity  = 1'b0;
    sleep_req = 1'b0;
    wake_req  = 1'b0;
    #1 rst = 1'b1;
    model_reset();
    #1 chk_all(tag);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    activity  = 1'b0;
    sleep_req = 1'b0;
    wake_req  = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk_all("reset");
    chk("reset_ready", {15'd0, ready}, 16'd1);
    rst = 1'b0;

    // Auto-sleep after IDLE idle edges, gated one edge later.
    for (int i = 0; i < IDLE - 1; i++) cyc(1'b0, 1'b0, 1'b0, "auto_idle");
    cyc(1'b0, 1'b0, 1'b0, "auto_enter");
    chk("auto_enter_state", {14'd0, state_o}, 16'd1);
    chk("auto_enter_ready", {15'd0, ready}, 16'd0);
    cyc(1'b0, 1'b0, 1'b0, "auto_sleep");
    chk("auto_sleep_pin", {15'd0, sleep}, 16'd1);

    // One-cycle wake pulse: ungated next edge, ready WAKE edges later.
    cyc(1'b0, 1'b0, 1'b1, "wake_start");
    chk("wake_start_state", {14'd0, state_o}, 16'd3);
    chk("wake_start_sleep", {15'd0, sleep}, 16'd0);
    for (int i = 0; i < WAKE - 1; i++) cyc(1'b0, 1'b0, 1'b0, "wake_settle");
    chk("wake_settle_ready", {15'd0, ready}, 16'd0);
    cyc(1'b0, 1'b0, 1'b0, "wake_done");
    chk("wake_done_ready", {15'd0, ready}, 16'd1);
    chk("wake_done_state", {14'd0, state_o}, 16'd0);

    // Interrupted idle window restarts the count.
    for (int i = 0; i < IDLE - 1; i++) cyc(1'b0, 1'b0, 1'b0, "intr_idle");
    cyc(1'b1, 1'b0, 1'b0, "intr_busy");
    for (int i = 0; i < IDLE - 1; i++) cyc(1'b0, 1'b0, 1'b0, "intr_idle2");
    chk("intr_still_active", {14'd0, state_o}, 16'd0);
    cyc(1'b0, 1'b0, 1'b0, "intr_enter");
    chk("intr_enter_state", {14'd0, state_o}, 16'd1);
    cyc(1'b1, 1'b0, 1'b1, "enter_ignores");
    chk("enter_ignores_state", {14'd0, state_o}, 16'd2);

    // Wake beats sleep in SLEEP.
    cyc(1'b0, 1'b1, 1'b1, "wake_vs_sleep");
    chk("wake_vs_sleep_state", {14'd0, state_o}, 16'd3);
    for (int i = 0; i < WAKE; i++) cyc(1'b0, 1'b1, 1'b0, "wake_ignores_sreq");
    chk("wake_ignores_sreq_state", {14'd0, state_o}, 16'd0);

    // Activity overrides sleep_req in ACTIVE.
    for (int i = 0; i < IDLE + 2; i++) cyc(1'b1, 1'b1, 1'b0, "prio_hold");
    chk("prio_hold_ready", {15'd0, ready}, 16'd1);
    cyc(1'b0, 1'b1, 1'b0, "prio_enter");
    chk("prio_enter_state", {14'd0, state_o}, 16'd1);
    cyc(1'b0, 1'b0, 1'b0, "prio_sleep");
    chk("prio_sleep_state", {14'd0, state_o}, 16'd2);

    // Asynchronous reset in the middle of WAKE.
    cyc(1'b0, 1'b0, 1'b1, "rstwake_start");
    cyc(1'b0, 1'b0, 1'b0, "rstwake_mid");
    chk("rstwake_in_wake", {14'd0, state_o}, 16'd3);
    do_reset("rst_async");
    chk("rst_async_state", {14'd0, state_o}, 16'd0);
    chk("rst_async_ready", {15'd0, ready}, 16'd1);
    chk("rst_async_sleep", {15'd0, sleep}, 16'd0);

    // Three full sleep/wake cycles.
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 1'b1, 1'b0, "stats_enter");
      cyc(1'b0, 1'b0, 1'b0, "stats_sleep");
      cyc(1'b0, 1'b0, 1'b1, "stats_wake");
      for (int i = 0; i < WAKE; i++) cyc(1'b0, 1'b0, 1'b0, "stats_settle");
    end
`ifdef MTCMOS_SLEEP_STATS_EN
    chk("stats_three", sleep_count, 16'd3);
`else
    chk("stats_three", sleep_count, 16'd0);
`endif

    // Randomized traffic with occasional asynchronous resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset("rand_rst");
      end else begin
        cyc(($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 15),
            ($urandom_range(0, 99) < 20), "rand");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
